// File: rtl/schmidl_cox_pkg.sv
// schmidl_cox_pkg
//   Shared definitions for the Schmidl-Cox sync controller: FSM state
//   encoding and its width. The state value is exported on the top-level
//   'state' port, so the encoding below is part of the block's interface.
package schmidl_cox_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_PLATEAU = 3'd2,
    ST_OFFSET  = 3'd3,
    ST_FORWARD = 3'd4,
    ST_HOLDOFF = 3'd5
  } sc_state_e;

endpackage

// File: rtl/sc_plateau_tracker.sv
// sc_plateau_tracker
//   Tracks one above-threshold run of the metric stream: run length,
//   maximum metric and the sample index of that maximum.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_clear             synchronous flush of run/peak registers
//   i_search            controller is looking for a plateau start
//   i_plateau           controller is inside a plateau
//   i_beat              a metric/sample beat is consumed this cycle
//   i_metric            metric of the current beat
//   i_threshold         inclusive detection threshold
//   i_index             sample counter value of the current beat
//   o_start             current beat opens a plateau
//   o_detect            current beat closes the plateau with a detection
//   o_abort             current beat closes a too-short plateau
//   o_peak_metric/index peak including the current beat (valid with o_detect)
module sc_plateau_tracker #(
  parameter int METRIC_WIDTH = 32,
  parameter int MIN_PLATEAU  = 8,
  parameter int MAX_PLATEAU  = 512
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic                    i_search,
  input  logic                    i_plateau,
  input  logic                    i_beat,
  input  logic [METRIC_WIDTH-1:0] i_metric,
  input  logic [METRIC_WIDTH-1:0] i_threshold,
  input  logic [31:0]             i_index,
  output logic                    o_start,
  output logic                    o_detect,
  output logic                    o_abort,
  output logic [METRIC_WIDTH-1:0] o_peak_metric,
  output logic [31:0]             o_peak_index
);

  localparam int RUN_W = $clog2(MAX_PLATEAU + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_PLATEAU);
  localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(MIN_PLATEAU);

  logic [RUN_W-1:0]        r_run;
  logic [METRIC_WIDTH-1:0] r_pk;
  logic [31:0]             r_pk_idx;

  logic             w_above;
  logic             w_new_max;
  logic             w_long_enough;
  logic [RUN_W-1:0] w_run_inc;

  assign w_above       = (i_metric >= i_threshold);
  assign w_long_enough = (r_run >= RUN_MIN);
  // Saturating increment; the run never needs to count past the forced limit.
  assign w_run_inc     = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);
  // Strict compare: on a tie the earliest maximum keeps its index.
  assign w_new_max     = w_above && (i_metric > r_pk);

  assign o_start  = i_search && i_beat && w_above;
  assign o_detect = i_plateau && i_beat &&
                    (w_above ? (w_run_inc == RUN_MAX) : w_long_enough);
  assign o_abort  = i_plateau && i_beat && !w_above && !w_long_enough;

  // A forced detection happens on an above-threshold beat that may itself
  // be the new maximum, so the peak handed out includes the current beat.
  assign o_peak_metric = (i_plateau && w_new_max) ? i_metric : r_pk;
  assign o_peak_index  = (i_plateau && w_new_max) ? i_index  : r_pk_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= '0;
      r_pk     <= '0;
      r_pk_idx <= '0;
    end else if (i_clear) begin
      r_run    <= '0;
      r_pk     <= '0;
      r_pk_idx <= '0;
    end else if (o_start) begin
      r_run    <= RUN_W'(1);
      r_pk     <= i_metric;
      r_pk_idx <= i_index;
    end else if (i_plateau && i_beat && w_above) begin
      r_run <= w_run_inc;
      if (w_new_max) begin
        r_pk     <= i_metric;
        r_pk_idx <= i_index;
      end
    end
  end

endmodule

// File: rtl/schmidl_cox_sync_ctrl.sv
// schmidl_cox_sync_ctrl
//   Follows the Schmidl-Cox metric calculator. Detects the metric plateau,
//   records its peak, skips an offset, forwards one frame of aligned samples
//   with tlast on the final beat, then holds off before re-arming.
// Ports:
//   clk, reset_n, clear      clock, async active-low reset, sync flush to IDLE
//   enable                   arm detector (dropping it finishes any frame first)
//   cfg_threshold/frame_len/offset/holdoff  latched on IDLE->SEARCH
//   m_tdata/m_tvalid/m_tready  metric stream
//   s_tdata/s_tvalid/s_tready  sample stream, index-aligned to the metric
//   o_tdata/o_tlast/o_tvalid/o_tready  gated frame output (one register stage)
//   det_pulse                one-cycle detection strobe
//   peak_metric/peak_index   peak of the last detected plateau
//   frame_count              completed frames, wraps
//   state                    current FSM state (sc_state_e encoding)
// Handshake: both input streams are consumed together; a beat transfers
// only when m_tvalid, s_tvalid and the internal ready are all high, and each
// side's tready is asserted only while the other side is valid. The output
// beat transfers when o_tvalid & o_tready; data and tlast hold while stalled.
module schmidl_cox_sync_ctrl
  import schmidl_cox_pkg::*;
#(
  parameter int METRIC_WIDTH = 32,
  parameter int SAMPLE_WIDTH = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int MIN_PLATEAU  = 8,
  parameter int MAX_PLATEAU  = 512
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [METRIC_WIDTH-1:0] cfg_threshold,
  input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
  input  logic [LEN_WIDTH-1:0]    cfg_offset,
  input  logic [LEN_WIDTH-1:0]    cfg_holdoff,
  input  logic [METRIC_WIDTH-1:0] m_tdata,
  input  logic                    m_tvalid,
  output logic                    m_tready,
  input  logic [SAMPLE_WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [SAMPLE_WIDTH-1:0] o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic                    det_pulse,
  output logic [METRIC_WIDTH-1:0] peak_metric,
  output logic [31:0]             peak_index,
  output logic [15:0]             frame_count,
  output logic [STATE_W-1:0]      state
);

  sc_state_e               r_state;
  logic [METRIC_WIDTH-1:0] r_thr;
  logic [LEN_WIDTH-1:0]    r_frame_len;
  logic [LEN_WIDTH-1:0]    r_offset;
  logic [LEN_WIDTH-1:0]    r_holdoff;
  logic [LEN_WIDTH-1:0]    r_len_cnt;
  logic [31:0]             r_cnt;
  logic                    r_det_pulse;
  logic [METRIC_WIDTH-1:0] r_peak_metric;
  logic [31:0]             r_peak_index;
  logic [15:0]             r_frame_count;
  logic [SAMPLE_WIDTH-1:0] r_o_tdata;
  logic                    r_o_tlast;
  logic                    r_o_tvalid;

  logic                    w_ready_int;
  logic                    w_beat;
  logic                    w_start;
  logic                    w_detect;
  logic                    w_abort;
  logic [METRIC_WIDTH-1:0] w_pk_metric;
  logic [31:0]             w_pk_index;
  logic [LEN_WIDTH-1:0]    w_len_inc;
  sc_state_e               w_rearm_state;

  // Only FORWARD can stall: the single output register accepts a new beat
  // when empty or when its current beat leaves this cycle.
  assign w_ready_int = (r_state != ST_FORWARD) || !r_o_tvalid || o_tready;
  assign w_beat      = m_tvalid && s_tvalid && w_ready_int;
  assign m_tready    = w_ready_int && s_tvalid;
  assign s_tready    = w_ready_int && m_tvalid;

  assign w_len_inc     = r_len_cnt + LEN_WIDTH'(1);
  assign w_rearm_state = enable ? ST_SEARCH : ST_IDLE;

  sc_plateau_tracker #(
    .METRIC_WIDTH (METRIC_WIDTH),
    .MIN_PLATEAU  (MIN_PLATEAU),
    .MAX_PLATEAU  (MAX_PLATEAU)
  ) u_tracker (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (clear),
    .i_search      (r_state == ST_SEARCH),
    .i_plateau     (r_state == ST_PLATEAU),
    .i_beat        (w_beat),
    .i_metric      (m_tdata),
    .i_threshold   (r_thr),
    .i_index       (r_cnt),
    .o_start       (w_start),
    .o_detect      (w_detect),
    .o_abort       (w_abort),
    .o_peak_metric (w_pk_metric),
    .o_peak_index  (w_pk_index)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_thr         <= '0;
      r_frame_len   <= LEN_WIDTH'(1);
      r_offset      <= '0;
      r_holdoff     <= '0;
      r_len_cnt     <= '0;
      r_cnt         <= '0;
      r_det_pulse   <= 1'b0;
      r_peak_metric <= '0;
      r_peak_index  <= '0;
      r_frame_count <= '0;
      r_o_tdata     <= '0;
      r_o_tlast     <= 1'b0;
      r_o_tvalid    <= 1'b0;
    end else if (clear) begin
      // Clear wins over a detection or output transfer in the same cycle.
      r_state       <= ST_IDLE;
      r_len_cnt     <= '0;
      r_cnt         <= '0;
      r_det_pulse   <= 1'b0;
      r_peak_metric <= '0;
      r_peak_index  <= '0;
      r_frame_count <= '0;
      r_o_tdata     <= '0;
      r_o_tlast     <= 1'b0;
      r_o_tvalid    <= 1'b0;
    end else begin
      r_det_pulse <= 1'b0;
      if (w_beat) r_cnt <= r_cnt + 32'd1;

      // Drain the output register; a load in FORWARD below overrides this.
      if (r_o_tvalid && o_tready) begin
        r_o_tvalid <= 1'b0;
        r_o_tlast  <= 1'b0;
        if (r_o_tlast) r_frame_count <= r_frame_count + 16'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_thr       <= cfg_threshold;
            r_frame_len <= (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
            r_offset    <= cfg_offset;
            r_holdoff   <= cfg_holdoff;
            r_len_cnt   <= '0;
            r_state     <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (!enable)      r_state <= ST_IDLE;
          else if (w_start) r_state <= ST_PLATEAU;
        end
        ST_PLATEAU: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_detect) begin
            // The beat that ends the plateau is consumed but not forwarded.
            r_det_pulse   <= 1'b1;
            r_peak_metric <= w_pk_metric;
            r_peak_index  <= w_pk_index;
            r_len_cnt     <= '0;
            r_state       <= (r_offset != '0) ? ST_OFFSET : ST_FORWARD;
          end else if (w_abort) begin
            r_state <= ST_SEARCH;
          end
        end
        ST_OFFSET: begin
          if (w_beat) begin
            if (w_len_inc == r_offset) begin
              r_len_cnt <= '0;
              r_state   <= ST_FORWARD;
            end else begin
              r_len_cnt <= w_len_inc;
            end
          end
        end
        ST_FORWARD: begin
          if (w_beat) begin
            r_o_tdata  <= s_tdata;
            r_o_tvalid <= 1'b1;
            r_o_tlast  <= (w_len_inc == r_frame_len);
            if (w_len_inc == r_frame_len) begin
              r_len_cnt <= '0;
              r_state   <= (r_holdoff != '0) ? ST_HOLDOFF : w_rearm_state;
            end else begin
              r_len_cnt <= w_len_inc;
            end
          end
        end
        ST_HOLDOFF: begin
          if (w_beat) begin
            if (w_len_inc == r_holdoff) begin
              r_len_cnt <= '0;
              r_state   <= w_rearm_state;
            end else begin
              r_len_cnt <= w_len_inc;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tdata     = r_o_tdata;
  assign o_tlast     = r_o_tlast;
  assign o_tvalid    = r_o_tvalid;
  assign det_pulse   = r_det_pulse;
  assign peak_metric = r_peak_metric;
  assign peak_index  = r_peak_index;
  assign frame_count = r_frame_count;
  assign state       = r_state;

endmodule

// File: tb/tb_schmidl_cox_sync_ctrl.sv
// Directed bench for schmidl_cox_sync_ctrl. Samples carry their own beat
// index so forwarded data can be predicted directly from the beat count.
module tb_schmidl_cox_sync_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SEARCH = 3'd1, S_PLATEAU = 3'd2,
                         S_OFFSET = 3'd3, S_FORWARD = 3'd4, S_HOLDOFF = 3'd5;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        enable;
  logic [31:0] cfg_threshold;
  logic [15:0] cfg_frame_len;
  logic [15:0] cfg_offset;
  logic [15:0] cfg_holdoff;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        det_pulse;
  logic [31:0] peak_metric;
  logic [31:0] peak_index;
  logic [15:0] frame_count;
  logic [2:0]  state;

  int          checks = 0;
  int          errors = 0;
  int          det_cnt = 0;
  int unsigned idx = 0;
  int unsigned first_idx;
  int unsigned d_idx;
  logic        bp_en = 1'b0;
  logic        r_stall = 1'b0;
  logic [32:0] r_held = '0;
  logic [32:0] exp_q[$];

  schmidl_cox_sync_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .enable        (enable),
    .cfg_threshold (cfg_threshold),
    .cfg_frame_len (cfg_frame_len),
    .cfg_offset    (cfg_offset),
    .cfg_holdoff   (cfg_holdoff),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .o_tdata       (o_tdata),
    .o_tlast       (o_tlast),
    .o_tvalid      (o_tvalid),
    .o_tready      (o_tready),
    .det_pulse     (det_pulse),
    .peak_metric   (peak_metric),
    .peak_index    (peak_index),
    .frame_count   (frame_count),
    .state         (state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one beat on both streams (sample = running beat index) and
  // waits, bounded, until it is consumed.
  task automatic send(input logic [31:0] metric);
    int t;
    m_tdata  = metric;
    s_tdata  = idx;
    m_tvalid = 1'b1;
    s_tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!m_tready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    assert (t < 50) else begin
      errors++;
      $error("FAIL send_timeout: observed=%0d cycles expected=<50", t);
    end
    @(posedge clk);
    #1;
    m_tvalid = 1'b0;
    s_tvalid = 1'b0;
    idx++;
  endtask

  task automatic push_frame(input int unsigned start, input int unsigned len);
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({(i == int'(len) - 1), 32'(start + i)});
  endtask

  // ---------------- backpressure toggler ----------------
  always @(posedge clk) begin
    #2;
    if (bp_en) o_tready = !o_tready;
  end

  // ---------------- scoreboard / monitors ----------------
  always @(posedge clk) begin
    if (reset_n && !clear) begin
      if (det_pulse) det_cnt++;
      if (r_stall) begin
        chk("hold_valid", o_tvalid, 1'b1);
        chk("hold_data", {o_tlast, o_tdata}, r_held);
      end
      if (o_tvalid && o_tready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL out_extra: observed=%0h expected=none", {o_tlast, o_tdata});
        end
        if (exp_q.size() > 0) chk("out_beat", {o_tlast, o_tdata}, exp_q.pop_front());
      end
    end
    r_stall = reset_n && o_tvalid && !o_tready;
    r_held  = {o_tlast, o_tdata};
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; clear = 1'b0; enable = 1'b0;
    cfg_threshold = 32'd100; cfg_frame_len = 16'd4;
    cfg_offset = 16'd0; cfg_holdoff = 16'd0;
    m_tdata = '0; m_tvalid = 1'b0; s_tdata = '0; s_tvalid = 1'b0;
    o_tready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, S_IDLE);
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_tlast", o_tlast, 1'b0);
    chk("rst_det", det_pulse, 1'b0);
    chk("rst_peak_metric", peak_metric, 32'd0);
    chk("rst_peak_index", peak_index, 32'd0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_m_tready_lone", m_tready, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", state, S_IDLE);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("arm_search", state, S_SEARCH);

    // Basic detection: plateau idx 2..11, peak 200 at idx 5, ends at idx 12
    push_frame(13, 4);
    send(0); send(0);
    send(150); send(150); send(180); send(200); send(180);
    send(150); send(180); send(150); send(180); send(150);
    chk("t1_plateau", state, S_PLATEAU);
    send(50);
    chk("t1_state_fwd", state, S_FORWARD);
    chk("t1_det", det_pulse, 1'b1);
    chk("t1_peak_metric", peak_metric, 32'd200);
    chk("t1_peak_index", peak_index, 32'd5);
    repeat (4) send(0);
    chk("t1_rearm", state, S_SEARCH);
    repeat (3) send(0);
    chk("t1_frame_count", frame_count, 16'd1);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_det_cnt", det_cnt, 1);

    // Short plateau: 5 beats above threshold is below the minimum
    send(150);
    chk("t2_plateau", state, S_PLATEAU);
    repeat (4) send(150);
    send(50);
    chk("t2_back_search", state, S_SEARCH);
    repeat (2) send(0);
    chk("t2_no_det", det_cnt, 1);
    chk("t2_no_frame", frame_count, 16'd1);

    // Long plateau: detection forced on the 512th above-threshold beat
    first_idx = idx;
    repeat (511) send(150);
    chk("t3_still_plateau", state, S_PLATEAU);
    send(150);
    chk("t3_forced_fwd", state, S_FORWARD);
    chk("t3_det", det_pulse, 1'b1);
    chk("t3_peak_metric", peak_metric, 32'd150);
    chk("t3_peak_index", peak_index, first_idx);
    push_frame(idx, 4);
    repeat (6) send(0);
    chk("t3_frame_count", frame_count, 16'd2);
    chk("t3_drained", exp_q.size(), 0);

    // Backpressure: offset 3, frame 8, o_tready toggling during the frame
    enable = 1'b0;
    @(posedge clk); #1;
    chk("t4_idle", state, S_IDLE);
    cfg_offset = 16'd3; cfg_frame_len = 16'd8;
    enable = 1'b1;
    @(posedge clk); #1;
    chk("t4_search", state, S_SEARCH);
    first_idx = idx;
    repeat (8) send(150);
    d_idx = idx;
    send(50);
    chk("t4_offset", state, S_OFFSET);
    chk("t4_det", det_pulse, 1'b1);
    chk("t4_peak_index", peak_index, first_idx);
    push_frame(d_idx + 4, 8);
    bp_en = 1'b1;
    repeat (3) send(0);
    chk("t4_forward", state, S_FORWARD);
    repeat (8) send(0);
    chk("t4_rearm", state, S_SEARCH);
    repeat (2) send(0);
    repeat (3) @(posedge clk);
    #1;
    bp_en = 1'b0;
    o_tready = 1'b1;
    @(posedge clk); #1;
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_frame_count", frame_count, 16'd3);

    // Stream skew: metric valid alone must not be consumed
    m_tdata = 32'd150; m_tvalid = 1'b1; s_tvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t5_m_tready_low", m_tready, 1'b0);
    end
    @(posedge clk); #1;
    m_tvalid = 1'b0;
    chk("t5_search", state, S_SEARCH);
    first_idx = idx;
    repeat (8) send(150);
    d_idx = idx;
    send(50);
    chk("t5_peak_index", peak_index, first_idx);
    chk("t5_det", det_pulse, 1'b1);
    chk("t5_offset", state, S_OFFSET);

    // Reset in the middle of FORWARD: second frame beat is truncated
    exp_q.push_back({1'b0, 32'(d_idx + 4)});
    repeat (5) send(0);
    chk("t6_forward", state, S_FORWARD);
    chk("t6_tvalid_busy", o_tvalid, 1'b1);
    chk("t6_tdata_busy", o_tdata, 32'(d_idx + 5));
    reset_n = 1'b0;
    #1;
    chk("t6_rst_state", state, S_IDLE);
    chk("t6_rst_tvalid", o_tvalid, 1'b0);
    chk("t6_rst_tdata", o_tdata, 32'd0);
    chk("t6_rst_tlast", o_tlast, 1'b0);
    chk("t6_rst_peak_metric", peak_metric, 32'd0);
    chk("t6_rst_peak_index", peak_index, 32'd0);
    chk("t6_rst_frame_count", frame_count, 16'd0);
    chk("t6_drained", exp_q.size(), 0);

    // Enable dropped inside PLATEAU: straight to IDLE, no detection
    idx = 0;
    cfg_offset = 16'd0; cfg_frame_len = 16'd4; cfg_holdoff = 16'd2;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t7_search", state, S_SEARCH);
    repeat (3) send(150);
    chk("t7_plateau", state, S_PLATEAU);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("t7_idle", state, S_IDLE);
    @(posedge clk); #1;
    chk("t7_no_det", det_pulse, 1'b0);
    chk("t7_det_cnt", det_cnt, 4);

    // Clear during HOLDOFF
    enable = 1'b1;
    @(posedge clk); #1;
    chk("t8_search", state, S_SEARCH);
    repeat (8) send(150);
    send(50);
    chk("t8_forward", state, S_FORWARD);
    push_frame(idx, 4);
    repeat (4) send(0);
    chk("t8_holdoff", state, S_HOLDOFF);
    @(posedge clk); #1;
    chk("t8_frame_count", frame_count, 16'd1);
    chk("t8_drained", exp_q.size(), 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("t8_clear_state", state, S_IDLE);
    chk("t8_clear_frame_count", frame_count, 16'd0);
    chk("t8_clear_peak_metric", peak_metric, 32'd0);
    chk("t8_clear_peak_index", peak_index, 32'd0);
    chk("t8_det_cnt", det_cnt, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/schmidl_cox_sync_ctrl.md
Name: schmidl_cox_sync_ctrl

Overview:
Sequencing controller placed after the Schmidl-Cox metric calculator. It consumes the normalised metric M(d) together with a sample stream that is already index-aligned to it. It detects the metric plateau and records the peak value and index. After a configurable offset it gates exactly one frame of samples to the downstream FFT path, appends tlast, then holds off before re-arming.

Parameters:
METRIC_WIDTH, 32, width of unsigned metric beats
SAMPLE_WIDTH, 32, width of sample beats ([I,Q] 16+16)
LEN_WIDTH, 16, width of frame/offset/holdoff length configs
MIN_PLATEAU, 8, minimum consecutive above-threshold beats to declare detection
MAX_PLATEAU, 512, plateau length at which detection is forced

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush to IDLE
enable  in  1  arm detector
cfg_threshold  in  METRIC_WIDTH  detection threshold, inclusive
cfg_frame_len  in  LEN_WIDTH  beats forwarded per frame
cfg_offset  in  LEN_WIDTH  beats dropped between detection and frame start
cfg_holdoff  in  LEN_WIDTH  beats dropped after frame
m_tdata/m_tvalid/m_tready  in/in/out  METRIC_WIDTH/1/1  metric stream (m_tlast ignored)
s_tdata/s_tvalid/s_tready  in/in/out  SAMPLE_WIDTH/1/1  aligned sample stream (s_tlast ignored)
o_tdata/o_tlast/o_tvalid/o_tready  out/out/out/in  SAMPLE_WIDTH/1/1/1  gated frame output
det_pulse  out  1  one-cycle detection strobe
peak_metric  out  METRIC_WIDTH  max metric of last detected plateau
peak_index  out  32  sample index of that max
frame_count  out  16  completed frames, wraps
state  out  3  current FSM state

Behaviour:
- Reset (async, reset_n=0) and clear: state=IDLE. o_tvalid, o_tlast, det_pulse = 0. peak_metric, peak_index, frame_count and the sample counter = 0. Output register is emptied. A mid-frame reset or clear truncates the frame with no tlast.
- Beat consumed iff m_tvalid & s_tvalid & ready_int, with m_tready = s_tready = ready_int & other-side valid. A lone-valid stream is never consumed.
- ready_int = 1 in every state except FORWARD. In FORWARD, ready_int = !o_tvalid | o_tready (single output register, latency 1 cycle, full throughput).
- Sample counter: 32-bit, +1 per consumed beat in any state, wraps. peak_index uses the counter value of the peak beat.
- Config inputs are latched on IDLE->SEARCH. Latched frame_len 0 is treated as 1.
- IDLE: beats dropped. enable=1 -> latch config, go to SEARCH.
- SEARCH: if metric >= thr -> PLATEAU with run=1, pk=metric, pk_idx=cnt.
- PLATEAU, beat with metric >= thr: run+1. Update pk/pk_idx only if metric > pk (strict, first max wins). If run reaches MAX_PLATEAU -> detect.
- PLATEAU, beat with metric < thr: if run >= MIN_PLATEAU -> detect, else go to SEARCH.
- Detect actions: det_pulse=1 on the next cycle, peak_metric/peak_index updated. Next state is OFFSET if offset != 0, else FORWARD. The beat that ended the plateau is dropped.
- OFFSET: drop cfg_offset beats, then FORWARD.
- FORWARD: pass cfg_frame_len beats. The last beat carries o_tlast=1. On acceptance of the last beat, frame_count+1, then HOLDOFF (or SEARCH if holdoff=0).
- HOLDOFF: drop cfg_holdoff beats, then SEARCH.
- enable=0: from SEARCH or PLATEAU go to IDLE immediately, with no detect. From OFFSET, FORWARD or HOLDOFF, the sequence completes, then IDLE instead of SEARCH.
- Simultaneous clear and detect: clear wins, no det_pulse. Run counter saturates at MAX_PLATEAU.
- Holding o_tvalid: o_tdata and o_tlast are held stable while o_tvalid & !o_tready.

Decomposition:
- Package schmidl_cox_pkg: state enum (IDLE, SEARCH, PLATEAU, OFFSET, FORWARD, HOLDOFF) and the 3-bit state width constant.
- Sub-module sc_plateau_tracker: run counter, threshold compare and max/index tracking. Outputs a detect/abort indication per beat.
- Top: FSM, length counters, output register.

Test Plan:
- Setup: thr=100, offset=0, frame_len=4, holdoff=0. Metric 0,0,then 150,200,180 ×(3 beats each… total 10 beats above thr, peak 200 at index 5), then 50. Samples = index. -> det_pulse once, peak_metric=200, peak_index=5. Output is samples 13..16 (first beat after the drop), tlast on 16.
- Short plateau: 5 beats >= thr with MIN_PLATEAU=8. -> no det_pulse, no output, state returns to SEARCH.
- Long plateau: 600 beats at 150. -> detect forced at run 512, peak_index = index of the first beat ≥ thr.
- Backpressure: o_tready toggling 1010… during FORWARD, offset=3, frame_len=8. -> exactly 8 beats, data stable while stalled, tlast only on the 8th. Input stalls only during FORWARD.
- Stream skew: s_tvalid low for 5 cycles while m_tvalid high. -> no consumption, counter frozen, detection unaffected.
- Mid-operation: reset_n asserted mid-FORWARD -> outputs 0 immediately. enable dropped in PLATEAU -> IDLE, no det_pulse. clear during HOLDOFF -> IDLE next cycle.
